// File: rtl/sr_multicycle_control.sv
// Multicycle sequencer for the schoolRISCV datapath: FETCH/DECODE/EXEC/WB control,
// retired-instruction counter and sticky illegal-opcode halt.
module sr_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imemReq,
  input  logic             imemAck,
  input  logic [6:0]       cmdOp,
  input  logic [2:0]       cmdF3,
  input  logic [6:0]       cmdF7,
  input  logic             aluZero,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             pcSrc,
  output logic             pcJal,
  output logic             regWrite,
  output logic             aluSrc,
  output logic             wdSrc,
  output logic [2:0]       aluControl,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  // ALU op encodings shared with the schoolRISCV datapath
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SRL  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic       r;
    logic       addi;
    logic       lui;
    logic       beq;
    logic       bne;
    logic       jal;
    logic [2:0] alu;
  } dec_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  dec_t             dec;
  logic             legal;
  logic             run_next;

  // Instruction register is stable from DECODE through WB, so decode is pure comb.
  always_comb begin
    dec = '0;
    dec.alu = ALU_ADD;
    case (cmdOp)
      OP_R: begin
        case ({cmdF7, cmdF3})
          10'b0000000_000: begin dec.r = 1'b1; dec.alu = ALU_ADD;  end
          10'b0100000_000: begin dec.r = 1'b1; dec.alu = ALU_SUB;  end
          10'b0000000_110: begin dec.r = 1'b1; dec.alu = ALU_OR;   end
          10'b0000000_101: begin dec.r = 1'b1; dec.alu = ALU_SRL;  end
          10'b0000000_011: begin dec.r = 1'b1; dec.alu = ALU_SLTU; end
          default: ;
        endcase
      end
      OP_IMM:  dec.addi = (cmdF3 == 3'b000);
      OP_LUI:  dec.lui  = 1'b1;
      OP_BR: begin
        dec.beq = (cmdF3 == 3'b000);
        dec.bne = (cmdF3 == 3'b001);
      end
      OP_JAL:  dec.jal  = 1'b1;
      default: ;
    endcase
  end

  assign legal    = dec.r | dec.addi | dec.lui | dec.beq | dec.bne | dec.jal;
  assign run_next = run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imemReq    = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    pcJal      = 1'b0;
    regWrite   = 1'b0;
    aluSrc     = 1'b0;
    wdSrc      = 1'b0;
    aluControl = ALU_ADD;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        imemReq = 1'b1;
        if (imemAck) begin
          irWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (dec.beq | dec.bne) begin
          aluControl = ALU_SUB;
          pcWrite    = 1'b1;
          pcSrc      = dec.beq ? aluZero : ~aluZero;
          state_d    = run_next ? S_FETCH : S_IDLE;
        end else if (dec.jal) begin
          regWrite = 1'b1;
          pcJal    = 1'b1;
          pcSrc    = 1'b1;
          pcWrite  = 1'b1;
          state_d  = run_next ? S_FETCH : S_IDLE;
        end else begin
          aluControl = dec.alu;
          aluSrc     = dec.addi;
          wdSrc      = dec.lui;
          state_d    = S_WB;
        end
      end
      S_WB: begin
        regWrite   = 1'b1;
        aluControl = dec.alu;
        aluSrc     = dec.addi;
        wdSrc      = dec.lui;
        pcWrite    = 1'b1;
        state_d    = run_next ? S_FETCH : S_IDLE;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // pcWrite fires exactly once per instruction, so it doubles as the retire strobe.
  assign retired_d = pcWrite ? retired_q + CNT_W'(1) : retired_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_sr_multicycle_control.sv
// Directed bench for sr_multicycle_control: walks each instruction class through
// the FSM and checks control vectors and the retire counter cycle by cycle.
module tb_sr_multicycle_control;

  localparam logic [2:0] A_ADD = 3'b000, A_OR = 3'b001, A_SRL = 3'b010,
                         A_SLTU = 3'b011, A_SUB = 3'b100;

  logic        clk = 1'b0;
  logic        rst, run, imemAck, aluZero;
  logic [6:0]  cmdOp, cmdF7;
  logic [2:0]  cmdF3;
  logic        imemReq, irWrite, pcWrite, pcSrc, pcJal, regWrite, aluSrc, wdSrc, halted;
  logic [2:0]  aluControl;
  logic [31:0] retired;
  logic [12:0] ctl_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret = 0;

  sr_multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .imemReq(imemReq), .imemAck(imemAck),
    .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7), .aluZero(aluZero),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .pcJal(pcJal),
    .regWrite(regWrite), .aluSrc(aluSrc), .wdSrc(wdSrc), .aluControl(aluControl),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  assign ctl_o = {imemReq, irWrite, pcWrite, pcSrc, pcJal, regWrite, aluSrc, wdSrc,
                  aluControl, halted};

  function automatic logic [12:0] C(input logic req, irw, pcw, pcs, jal, rw, as, wd,
                                    input logic [2:0] alu, input logic h);
    return {req, irw, pcw, pcs, jal, rw, as, wd, alu, h};
  endfunction

  task automatic chk_c(input string tag, input logic [12:0] exp);
    checks++;
    assert (ctl_o === exp) else begin
      errors++;
      $error("FAIL %s: ctl observed %b expected %b", tag, ctl_o, exp);
    end
  endtask

  task automatic chk_r(input string tag, input logic [31:0] exp);
    checks++;
    assert (retired === exp) else begin
      errors++;
      $error("FAIL %s: retired observed %0d expected %0d", tag, retired, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    cmdOp = op; cmdF3 = f3; cmdF7 = f7;
  endtask

  // Entered in FETCH; leaves in the state after WB.
  task automatic do_alu(input string nm, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [2:0] alu, input logic as, wd);
    set_ins(op, f3, f7);
    imemAck = 1'b1;
    settle(); chk_c({nm, " fetch"}, C(1,1,0,0,0,0,0,0,A_ADD,0)); chk_r({nm, " ret0"}, exp_ret);
    tick();
    settle(); chk_c({nm, " decode"}, C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c({nm, " exec"}, C(0,0,0,0,0,0,as,wd,alu,0));
    tick();
    settle(); chk_c({nm, " wb"}, C(0,0,1,0,0,1,as,wd,alu,0));
    tick();
    exp_ret++;
  endtask

  task automatic do_br(input string nm, input logic [2:0] f3, input logic z, input logic pcs);
    set_ins(7'b1100011, f3, 7'b0000000);
    imemAck = 1'b1;
    aluZero = z;
    settle(); chk_c({nm, " fetch"}, C(1,1,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c({nm, " decode"}, C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c({nm, " exec"}, C(0,0,1,pcs,0,0,0,0,A_SUB,0)); chk_r({nm, " ret pre"}, exp_ret);
    tick();
    exp_ret++;
    settle(); chk_r({nm, " ret post"}, exp_ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; imemAck = 1'b0; aluZero = 1'b0;
    set_ins(7'b0010011, 3'b000, 7'b0000000);
    #3;
    chk_c("reset ctl", C(0,0,0,0,0,0,0,0,A_ADD,0));
    chk_r("reset retired", 32'd0);
    tick();
    rst = 1'b0;
    settle(); chk_c("idle run0", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c("idle hold", C(0,0,0,0,0,0,0,0,A_ADD,0));
    run = 1'b1;
    settle(); chk_c("idle run1", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();

    // ADDI stream, ack on first FETCH cycle
    for (int i = 0; i < 3; i++)
      do_alu("addi", 7'b0010011, 3'b000, 7'b0000000, A_ADD, 1'b1, 1'b0);
    settle(); chk_r("addi x3 retired", 32'd3);

    // Delayed ack: five wait cycles then the ack cycle
    set_ins(7'b0110011, 3'b000, 7'b0000000);
    imemAck = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle(); chk_c("fetch wait", C(1,0,0,0,0,0,0,0,A_ADD,0));
      tick();
    end
    imemAck = 1'b1;
    settle(); chk_c("fetch ack", C(1,1,0,0,0,0,0,0,A_ADD,0));
    tick();
    imemAck = 1'b0;
    settle(); chk_c("add decode", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c("add exec", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c("add wb", C(0,0,1,0,0,1,0,0,A_ADD,0));
    tick();
    exp_ret++;

    do_alu("sub",  7'b0110011, 3'b000, 7'b0100000, A_SUB,  1'b0, 1'b0);
    do_alu("or",   7'b0110011, 3'b110, 7'b0000000, A_OR,   1'b0, 1'b0);
    do_alu("srl",  7'b0110011, 3'b101, 7'b0000000, A_SRL,  1'b0, 1'b0);
    do_alu("sltu", 7'b0110011, 3'b011, 7'b0000000, A_SLTU, 1'b0, 1'b0);
    do_alu("lui",  7'b0110111, 3'b101, 7'b1010101, A_ADD,  1'b0, 1'b1);

    do_br("beq z1", 3'b000, 1'b1, 1'b1);
    do_br("bne z1", 3'b001, 1'b1, 1'b0);
    do_br("beq z0", 3'b000, 1'b0, 1'b0);
    do_br("bne z0", 3'b001, 1'b0, 1'b1);
    aluZero = 1'b0;

    // JAL: everything in EXEC, then straight back to FETCH
    set_ins(7'b1101111, 3'b010, 7'b0110011);
    imemAck = 1'b1;
    settle(); chk_c("jal fetch", C(1,1,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c("jal decode", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c("jal exec", C(0,0,1,1,1,1,0,0,A_ADD,0));
    tick();
    exp_ret++;
    imemAck = 1'b0;
    settle(); chk_c("jal no wb", C(1,0,0,0,0,0,0,0,A_ADD,0));
    chk_r("jal retired", exp_ret);

    // run dropped during EXEC: instruction finishes, then IDLE
    set_ins(7'b0010011, 3'b000, 7'b0000000);
    imemAck = 1'b1;
    settle(); chk_c("stop fetch", C(1,1,0,0,0,0,0,0,A_ADD,0));
    tick();
    tick();
    run = 1'b0;
    settle(); chk_c("stop exec", C(0,0,0,0,0,0,1,0,A_ADD,0));
    tick();
    settle(); chk_c("stop wb", C(0,0,1,0,0,1,1,0,A_ADD,0));
    tick();
    exp_ret++;
    settle(); chk_c("stop idle", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c("stop idle hold", C(0,0,0,0,0,0,0,0,A_ADD,0));
    chk_r("stop retired", exp_ret);

    // rst pulsed during WB
    run = 1'b1;
    tick(); tick(); tick(); tick();
    settle(); chk_c("rst pre wb", C(0,0,1,0,0,1,1,0,A_ADD,0));
    rst = 1'b1;
    #1;
    chk_c("rst mid wb", C(0,0,0,0,0,0,0,0,A_ADD,0));
    chk_r("rst mid retired", 32'd0);
    exp_ret = 0;
    tick();
    rst = 1'b0;
    settle(); chk_c("rst idle", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();

    // Load opcode is illegal: HALT is sticky and ignores acks
    set_ins(7'b0000011, 3'b010, 7'b0000000);
    imemAck = 1'b1;
    settle(); chk_c("ld fetch", C(1,1,0,0,0,0,0,0,A_ADD,0));
    tick();
    settle(); chk_c("ld decode", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();
    for (int i = 0; i < 20; i++) begin
      settle(); chk_c("halt", C(0,0,0,0,0,0,0,0,A_ADD,1));
      chk_r("halt retired", exp_ret);
      tick();
    end
    rst = 1'b1;
    #1;
    chk_c("halt rst", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();
    rst = 1'b0;
    settle(); chk_c("post halt idle", C(0,0,0,0,0,0,0,0,A_ADD,0));
    tick();

    // R-type with a non-zero funct7 outside the legal set also halts
    set_ins(7'b0110011, 3'b000, 7'b0000001);
    settle(); chk_c("mul fetch", C(1,1,0,0,0,0,0,0,A_ADD,0));
    tick();
    tick();
    settle(); chk_c("mul halt", C(0,0,0,0,0,0,0,0,A_ADD,1));
    chk_r("mul retired", 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
